// File: rtl/i2c_master_ctrl.sv
// Single-byte open-drain I2C master: ADDR/DATA load registers, READ/WRITE run one framed byte.
// A transaction takes 80 clk at QDIV=1 (44 on address NACK); SCL stretching stalls it in q1.
module i2c_master_ctrl #(
    parameter int QDIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inp,
    input  logic [2:0] cmd,
    output logic [7:0] out,
    output logic       stat,
    inout  wire        scl,
    inout  wire        sda
);
    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    localparam logic [2:0] CMD_ADDR  = 3'd1;
    localparam logic [2:0] CMD_DATA  = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_WRITE = 3'd4;

    typedef enum logic [3:0] {
        IDLE, START, ADDR_BITS, ADDR_ACK, WR_BITS, WR_ACK, RD_BITS, RD_NACK, STOP
    } state_t;

    state_t          state, state_n;
    logic [1:0]      phase, phase_n;
    logic [QW-1:0]   qcnt, qcnt_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      sh, sh_n;
    logic [7:0]      wr_byte, wr_byte_n;
    logic [7:0]      rx, rx_n;
    logic            rd_op, rd_op_n;
    logic            samp, samp_n;
    logic [7:0]      out_n;
    logic [6:0]      addr_reg, addr_n;
    logic [7:0]      data_reg, data_n;
    logic            adv;
    logic            scl_low, sda_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            qcnt     <= '0;
            bitcnt   <= '0;
            sh       <= '0;
            wr_byte  <= '0;
            rx       <= '0;
            rd_op    <= 1'b0;
            samp     <= 1'b0;
            out      <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            qcnt     <= qcnt_n;
            bitcnt   <= bitcnt_n;
            sh       <= sh_n;
            wr_byte  <= wr_byte_n;
            rx       <= rx_n;
            rd_op    <= rd_op_n;
            samp     <= samp_n;
            out      <= out_n;
            addr_reg <= addr_n;
            data_reg <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        qcnt_n    = qcnt;
        bitcnt_n  = bitcnt;
        sh_n      = sh;
        wr_byte_n = wr_byte;
        rx_n      = rx;
        rd_op_n   = rd_op;
        samp_n    = samp;
        out_n     = out;
        addr_n    = addr_reg;
        data_n    = data_reg;
        adv       = 1'b0;
        scl_low   = 1'b0;
        sda_low   = 1'b0;

        if (cmd == CMD_ADDR) addr_n = inp[6:0];
        if (cmd == CMD_DATA) data_n = inp;

        if (state == IDLE) begin
            phase_n = '0;
            qcnt_n  = '0;
            // Both bytes are captured here so later ADDR/DATA only affect the next transaction.
            if (cmd == CMD_READ || cmd == CMD_WRITE) begin
                state_n   = START;
                rd_op_n   = (cmd == CMD_READ);
                sh_n      = {addr_reg, cmd == CMD_READ};
                wr_byte_n = data_reg;
                bitcnt_n  = '0;
            end
        end else if (phase == 2'd1 && state != START && !scl) begin
            qcnt_n = '0;
        end else if (qcnt == QLAST) begin
            adv    = 1'b1;
            qcnt_n = '0;
        end else begin
            qcnt_n = qcnt + 1'b1;
        end

        if (adv) begin
            phase_n = phase + 2'd1;
            if (phase == 2'd2) begin
                samp_n = sda;
                if (state == RD_BITS) rx_n = {rx[6:0], sda};
            end
            if (phase == 2'd3) begin
                case (state)
                    START: begin
                        state_n  = ADDR_BITS;
                        bitcnt_n = '0;
                    end
                    ADDR_BITS, WR_BITS: begin
                        sh_n     = {sh[6:0], 1'b0};
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state_n = (state == ADDR_BITS) ? ADDR_ACK : WR_ACK;
                    end
                    ADDR_ACK: begin
                        if (samp) begin
                            state_n = STOP;
                        end else if (rd_op) begin
                            state_n = RD_BITS;
                        end else begin
                            state_n = WR_BITS;
                            sh_n    = wr_byte;
                        end
                    end
                    WR_ACK:  state_n = STOP;
                    RD_BITS: begin
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state_n = RD_NACK;
                    end
                    RD_NACK: begin
                        state_n = STOP;
                        out_n   = rx;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        case (state)
            START: begin
                sda_low = (phase != 2'd0);
                scl_low = (phase == 2'd3);
            end
            ADDR_BITS, WR_BITS: begin
                scl_low = (phase == 2'd0 || phase == 2'd3);
                sda_low = ~sh[7];
            end
            ADDR_ACK, WR_ACK, RD_BITS, RD_NACK: begin
                scl_low = (phase == 2'd0 || phase == 2'd3);
            end
            STOP: begin
                scl_low = (phase == 2'd0);
                sda_low = (phase != 2'd3);
            end
            default: ;
        endcase
    end

    assign stat = (state != IDLE);
    assign scl  = scl_low ? 1'b0 : 1'bz;
    assign sda  = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl with a clk-sampled I2C responder at address 0x77 and a bus monitor.
module tb_i2c_master_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inp;
    logic [2:0] cmd;
    logic [7:0] out;
    logic       stat;
    wire        scl;
    wire        sda;
    logic       tb_scl_low = 1'b0;
    logic [7:0] slave_mem;

    pullup (scl);
    pullup (sda);
    assign scl = tb_scl_low ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.QDIV(1)) dut (
        .clk(clk), .rst(rst), .inp(inp), .cmd(cmd),
        .out(out), .stat(stat), .scl(scl), .sda(sda)
    );

    i2c_slave #(.ADDR(7'h77)) slv (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .mem(slave_mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_mem = 8'h00;
    logic [7:0] model_out = 8'h00;

    // Bus monitor: decodes START/STOP and 9-bit byte frames from the wires alone.
    int         mon_starts = 0;
    int         mon_stops  = 0;
    int         mon_edges  = 0;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];
    int         m_bits = 0;
    logic [7:0] m_sh   = 8'h00;
    logic       m_ps   = 1'b1;
    logic       m_pd   = 1'b1;

    always @(negedge clk) begin
        if (scl !== m_ps || sda !== m_pd) mon_edges++;
        if (m_ps && scl && m_pd && !sda) begin
            mon_starts++;
            m_bits = 0;
            m_sh   = 8'h00;
        end else if (m_ps && scl && !m_pd && sda) begin
            mon_stops++;
        end else if (!m_ps && scl) begin
            if (m_bits < 8) begin
                m_sh = {m_sh[6:0], sda};
            end else begin
                mon_bytes.push_back(m_sh);
                mon_acks.push_back(sda);
            end
            m_bits = (m_bits == 8) ? 0 : m_bits + 1;
        end
        m_ps = scl;
        m_pd = sda;
    end

    // Clock stretcher: holds SCL low for 10 clk from the start of address bit 3.
    logic stretch_arm = 1'b0;
    int   st_falls = 0;
    int   st_left  = 0;
    int   stretch_applied = 0;
    logic st_ps = 1'b1;

    always @(negedge clk) begin
        if (!stretch_arm) begin
            st_falls   = 0;
            st_left    = 0;
            tb_scl_low = 1'b0;
        end else if (st_left > 0) begin
            st_left--;
            if (st_left == 0) begin
                tb_scl_low = 1'b0;
                stretch_applied++;
            end
        end else if (st_ps && !scl && st_falls <= 3) begin
            if (st_falls == 3) begin
                tb_scl_low = 1'b1;
                st_left    = 10;
            end
            st_falls++;
        end
        st_ps = scl;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] v);
        @(negedge clk);
        cmd = c;
        inp = v;
        @(posedge clk);
        #1;
        cmd = 3'd0;
        inp = 8'h00;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (stat && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One transaction checked against the byte-level bus model held in model_mem/model_out.
    task automatic do_txn(input string tag, input logic [7:0] a, input logic [7:0] d, input bit rd,
                          input bit setup, input logic [7:0] exp_out, input int exp_cyc);
        int   s0, p0, b0, cyc;
        bit   hit;
        logic [7:0] frame, second;
        hit    = (a[6:0] == 7'h77);
        frame  = {a[6:0], rd};
        second = rd ? model_mem : d;
        if (setup) begin
            issue(3'd1, a);
            issue(3'd2, d);
        end
        s0 = mon_starts;
        p0 = mon_stops;
        b0 = mon_bytes.size();
        issue(rd ? 3'd3 : 3'd4, 8'h00);
        check({tag, "_stat_rise"}, stat, 1);
        wait_idle(cyc);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_starts"}, mon_starts - s0, 1);
        check({tag, "_stops"}, mon_stops - p0, 1);
        check({tag, "_nbytes"}, mon_bytes.size() - b0, hit ? 2 : 1);
        if (mon_bytes.size() > b0) begin
            check({tag, "_frame"}, mon_bytes[b0], frame);
            check({tag, "_ack0"}, mon_acks[b0], !hit);
        end
        if (hit && mon_bytes.size() > b0 + 1) begin
            check({tag, "_byte1"}, mon_bytes[b0+1], second);
            check({tag, "_ack1"}, mon_acks[b0+1], rd);
        end
        if (hit && !rd) model_mem = d;
        if (hit && rd)  model_out = model_mem;
        check({tag, "_slave_mem"}, slave_mem, model_mem);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         rd;
        logic [7:0] exp_out;
        int         exp_cycles;
    } vec_t;

    vec_t vt[7];

    initial begin
        int s0, e0, b0, cyc;
        logic [7:0] a, d;
        bit rd, hit;

        vt[0] = '{8'h77, 8'hAB, 1'b0, 8'h00, 80};
        vt[1] = '{8'h77, 8'h00, 1'b1, 8'hAB, 80};
        vt[2] = '{8'h12, 8'h33, 1'b0, 8'hAB, 44};
        vt[3] = '{8'h12, 8'h00, 1'b1, 8'hAB, 44};
        vt[4] = '{8'h77, 8'h5C, 1'b0, 8'hAB, 80};
        vt[5] = '{8'h77, 8'h00, 1'b1, 8'h5C, 80};
        vt[6] = '{8'hF7, 8'h00, 1'b1, 8'h5C, 80};

        rst = 1'b1;
        cmd = 3'd0;
        inp = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out", out, 8'h00);
        check("reset_stat", stat, 0);
        check("reset_scl", scl, 1);
        check("reset_sda", sda, 1);
        e0 = mon_edges;
        repeat (50) @(posedge clk);
        #1;
        check("idle_edges", mon_edges - e0, 0);
        check("idle_stat", stat, 0);

        for (int i = 0; i < 7; i++)
            do_txn($sformatf("vec%0d", i), vt[i].a, vt[i].d, vt[i].rd, 1'b1,
                   vt[i].exp_out, vt[i].exp_cycles);

        // Commands while busy are ignored; a DATA write only affects the next WRITE.
        issue(3'd1, 8'h77);
        issue(3'd2, 8'hC3);
        s0 = mon_starts;
        b0 = mon_bytes.size();
        issue(3'd4, 8'h00);
        check("busy_stat_rise", stat, 1);
        issue(3'd3, 8'h00);
        issue(3'd4, 8'h00);
        issue(3'd5, 8'hFF);
        issue(3'd6, 8'hFF);
        issue(3'd7, 8'hFF);
        issue(3'd2, 8'h55);
        wait_idle(cyc);
        check("busy_cycles", cyc + 6, 80);
        repeat (20) @(posedge clk);
        #1;
        check("busy_starts", mon_starts - s0, 1);
        check("busy_nbytes", mon_bytes.size() - b0, 2);
        if (mon_bytes.size() > b0 + 1) begin
            check("busy_frame", mon_bytes[b0], 8'hEE);
            check("busy_byte1", mon_bytes[b0+1], 8'hC3);
        end
        check("busy_slave_mem", slave_mem, 8'hC3);
        model_mem = 8'hC3;
        do_txn("next_write", 8'h77, 8'h55, 1'b0, 1'b0, model_out, 80);

        stretch_arm = 1'b1;
        do_txn("stretch", 8'h77, 8'h00, 1'b1, 1'b1, 8'h55, 88);
        stretch_arm = 1'b0;
        check("stretch_applied", stretch_applied, 1);

        for (int i = 0; i < 16; i++) begin
            a    = ($urandom_range(0, 1) == 1) ? 8'h77 : 8'($urandom_range(0, 127));
            a[7] = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            rd   = 1'($urandom_range(0, 1));
            hit  = (a[6:0] == 7'h77);
            do_txn($sformatf("rnd%0d", i), a, d, rd, 1'b1,
                   (hit && rd) ? model_mem : model_out, hit ? 80 : 44);
        end

        // Reset in the middle of the read data phase.
        issue(3'd1, 8'h77);
        issue(3'd3, 8'h00);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda, 1);
        check("midrst_stat", stat, 0);
        check("midrst_out", out, 8'h00);
        rst = 1'b0;
        model_out = 8'h00;
        s0 = mon_starts;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_quiet", mon_starts - s0, 0);
        do_txn("after_rst", 8'h77, 8'h00, 1'b1, 1'b1, model_mem, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// Bus responder: samples the wires on falling clk, ACKs its address and written data, returns the stored byte.
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h77
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] mem
);
    localparam int S_IDLE = 0, S_ADDR = 1, S_AACK = 2, S_WR = 3, S_WACK = 4, S_RD = 5, S_RNACK = 6;

    logic       drv = 1'b0;
    logic       ps  = 1'b1;
    logic       pd  = 1'b1;
    int         st  = S_IDLE;
    int         cnt = 0;
    logic [7:0] sh  = 8'h00;
    logic       rw  = 1'b0;
    logic [7:0] mem_r = 8'h00;

    assign sda = drv ? 1'b0 : 1'bz;
    assign mem = mem_r;

    always @(negedge clk) begin
        if (rst) begin
            drv = 1'b0;
            st  = S_IDLE;
        end else if (ps && scl && pd && !sda) begin
            st  = S_ADDR;
            cnt = 0;
            sh  = 8'h00;
            drv = 1'b0;
        end else if (ps && scl && !pd && sda) begin
            st  = S_IDLE;
            drv = 1'b0;
        end else if (!ps && scl) begin
            if (st == S_ADDR || st == S_WR) begin
                sh = {sh[6:0], sda};
                cnt++;
            end else if (st == S_RD) begin
                cnt++;
            end
        end else if (ps && !scl) begin
            case (st)
                S_ADDR: if (cnt == 8) begin
                    if (sh[7:1] == ADDR) begin
                        drv = 1'b1;
                        rw  = sh[0];
                        st  = S_AACK;
                    end else begin
                        st = S_IDLE;
                    end
                end
                S_AACK: begin
                    cnt = 0;
                    if (rw) begin
                        st  = S_RD;
                        drv = !mem_r[7];
                    end else begin
                        st  = S_WR;
                        sh  = 8'h00;
                        drv = 1'b0;
                    end
                end
                S_WR: if (cnt == 8) begin
                    mem_r = sh;
                    drv   = 1'b1;
                    st    = S_WACK;
                end
                S_WACK: begin
                    drv = 1'b0;
                    st  = S_IDLE;
                end
                S_RD: begin
                    if (cnt == 8) begin
                        drv = 1'b0;
                        st  = S_RNACK;
                    end else begin
                        drv = !mem_r[7-cnt];
                    end
                end
                S_RNACK: st = S_IDLE;
                default: ;
            endcase
        end
        ps = scl;
        pd = sda;
    end
endmodule
